// File: rtl/pipeline_muldiv_ctrl_if.sv
// rtl/pipeline_muldiv_ctrl_if.sv - EX-side handshake bundle for the mul/div sequencer
//
// Signals (master = EX stage / pipeline control, slave = mul/div unit):
//   start, op[1:0], opA[31:0], opB[31:0]   mul/div issue from EX
//   rd_hilo                                MFHI/MFLO in EX
//   wr_hi, wr_lo, wr_data[31:0]            MTHI/MTLO in EX
//   flush                                  EX instruction squashed
//   hi[31:0], lo[31:0]                     architectural HI/LO
//   busy, stall, done                      unit status and pipeline freeze

interface pipeline_muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        rd_hilo;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output start, op, opA, opB, rd_hilo, wr_hi, wr_lo, wr_data, flush,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, opA, opB, rd_hilo, wr_hi, wr_lo, wr_data, flush,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/pipeline_muldiv_ctrl.sv
// rtl/pipeline_muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
//
// Ports:
//   clk    pipeline clock
//   reset  synchronous active-high reset
//   bus    pipeline_muldiv_ctrl_if.slave (issue, MTHI/MTLO, MFHI/MFLO, HI/LO, busy/stall/done)
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   - MULT/MULTU bypass CALC and use a single-cycle 32x32 multiply (2-cycle latency)
//   undefined - every op takes the 33-cycle iterative path

module pipeline_muldiv_ctrl (
  input logic                    clk,
  input logic                    reset,
  pipeline_muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Shared working register: multiply = {partial product, multiplier},
  // divide = {remainder, quotient/dividend}.
  logic [63:0] acc_q, acc_d;
  // Multiplicand for multiply, divisor for divide (always a magnitude).
  logic [31:0] mcand_q, mcand_d;
  logic        is_div_q, is_div_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef MULDIV_FAST_MUL_EN
  // Set when FIXUP still has to form the product with the fast multiplier.
  logic        fast_q, fast_d;
`endif

  logic        stall;
  logic        accept;
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] mul_res;
  logic [31:0] quo_res, rem_res;

  // Operand-independent: only registered busy and the EX decode bits.
  assign stall = busy_q & (bus.start | bus.rd_hilo | bus.wr_hi | bus.wr_lo);

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.opA[31];
  assign b_neg     = signed_op & bus.opB[31];
  assign a_mag     = a_neg ? (32'd0 - bus.opA) : bus.opA;
  assign b_mag     = b_neg ? (32'd0 - bus.opB) : bus.opB;

  // Shift-add step: add multiplicand into the upper half on multiplier LSB,
  // then shift the whole 65-bit {carry, acc} right by one.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring-divide step: bring the next dividend bit into the remainder,
  // trial-subtract, keep the difference only when it did not borrow.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
  assign div_next  = div_diff[33] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0],  acc_q[30:0], 1'b1};

  // Sign fixup. With a zero divisor the remainder path already holds |opA|,
  // and re-applying the dividend sign restores opA itself.
  assign mul_res = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;
  assign quo_res = div0_q ? 32'hFFFF_FFFF
                 : ((sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
  assign rem_res = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  assign accept = (state_q == IDLE) & bus.start & ~bus.flush & ~stall;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fast_d   = fast_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d    = {32'd0, a_mag};
          mcand_d  = b_mag;
          cnt_d    = 5'd0;
          is_div_d = bus.op[1];
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          div0_d   = bus.op[1] & (bus.opB == 32'd0);
          state_d  = CALC;
`ifdef MULDIV_FAST_MUL_EN
          if (!bus.op[1]) begin
            state_d = FIXUP;
            fast_d  = 1'b1;
          end
`endif
        end else if (!bus.flush) begin
          if (bus.wr_hi) hi_d = bus.wr_data;
          if (bus.wr_lo) lo_d = bus.wr_data;
        end
      end

      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd0;
          state_d = FIXUP;
        end
      end

      FIXUP: begin
`ifdef MULDIV_FAST_MUL_EN
        if (fast_q) begin
          // First FIXUP cycle forms the full product; the second commits it.
          acc_d  = {32'd0, mcand_q} * {32'd0, acc_q[31:0]};
          fast_d = 1'b0;
        end else begin
          hi_d    = is_div_q ? rem_res : mul_res[63:32];
          lo_d    = is_div_q ? quo_res : mul_res[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
`else
        hi_d    = is_div_q ? rem_res : mul_res[63:32];
        lo_d    = is_div_q ? quo_res : mul_res[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 32'd0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fast_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULDIV_FAST_MUL_EN
      fast_q   <= fast_d;
`endif
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.stall = stall;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_pipeline_muldiv_ctrl.sv
// tb/tb_pipeline_muldiv_ctrl.sv - self-checking bench for pipeline_muldiv_ctrl

module tb_pipeline_muldiv_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipeline_muldiv_ctrl_if bus ();

  pipeline_muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic on the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin
        q = sa * sb;
        return q;
      end
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic int lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 2;
`endif
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.done === 1'b1) begin
        edges = k;
        return;
      end
    end
    failures++;
    checks++;
    $display("FAIL done_timeout actual=none expected=done within 200 cycles");
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(op, a, b);
    chk({name, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(n);
    chk({name, "_latency"}, 64'(n), 64'(lat(op)));
    chk({name, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, "_lo"}, 64'(bus.lo), 64'(elo));
    chk({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    step();
    chk({name, "_done_once"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int          n;
    int          bad;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] exp;
    logic [31:0] hold_hi;

    checks    = 0;
    failures  = 0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.opA     = 32'd0;
    bus.opB     = 32'd0;
    bus.rd_hilo = 1'b0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = 32'd0;
    bus.flush   = 1'b0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b10, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    vecs[5] = '{2'b01, 32'h0001_0000, 32'h0001_0000,  32'd1,         32'd0};
    vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{2'b01, 32'hFFFF_FFFF, 32'd2,          32'd1,         32'hFFFF_FFFE};

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_hi",    64'(bus.hi),    64'd0);
    chk("reset_lo",    64'(bus.lo),    64'd0);
    chk("reset_busy",  64'(bus.busy),  64'd0);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    chk("reset_done",  64'(bus.done),  64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0
          : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i == 0) begin
        ra = 32'h8000_0000;
        rb = 32'd0;
      end
      exp = model(rop, ra, rb);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, exp[63:32], exp[31:0]);
    end

    // MFLO right behind MULTU: stalled for the whole operation, free on done.
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    bus.rd_hilo = 1'b1;
    chk("haz_stall_first", 64'(bus.stall), 64'd1);
    bad = 0;
    n   = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.done === 1'b1) begin
        n = k;
        break;
      end
      if (bus.stall !== 1'b1) bad++;
    end
    chk("haz_stall_held", 64'(bad), 64'd0);
    chk("haz_latency", 64'(n), 64'(lat(2'b01)));
    chk("haz_stall_release", 64'(bus.stall), 64'd0);
    chk("haz_lo", 64'(bus.lo), 64'd0);
    chk("haz_hi", 64'(bus.hi), 64'd1);
    bus.rd_hilo = 1'b0;
    step();

    // Second start held while busy, accepted in the done cycle.
    issue(2'b11, 32'd100, 32'd7);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opA   = 32'hFFFF_FFFD;
    bus.opB   = 32'd7;
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.done === 1'b1) break;
      if (bus.stall !== 1'b1) bad++;
    end
    chk("held_stall", 64'(bad), 64'd0);
    chk("held_first_hi", 64'(bus.hi), 64'd2);
    chk("held_first_lo", 64'(bus.lo), 64'd14);
    chk("held_stall_release", 64'(bus.stall), 64'd0);
    step();
    bus.start = 1'b0;
    chk("held_accepted", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("held_second_latency", 64'(n), 64'(lat(2'b00)));
    chk("held_second_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("held_second_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    step();

    // MTHI/MTLO and flush in IDLE.
    hold_hi = bus.hi;
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h1234;
    bus.flush   = 1'b1;
    step();
    bus.wr_hi = 1'b0;
    bus.flush = 1'b0;
    chk("mthi_flushed", 64'(bus.hi), 64'(hold_hi));
    bus.wr_hi = 1'b1;
    step();
    bus.wr_hi = 1'b0;
    chk("mthi_write", 64'(bus.hi), 64'h1234);
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hABCD;
    step();
    bus.wr_lo = 1'b0;
    chk("mtlo_write", 64'(bus.lo), 64'hABCD);

    // Flushed start never launches.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b11;
    bus.opA   = 32'd9;
    bus.opB   = 32'd3;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", 64'(bus.busy), 64'd0);

    // MTHI during an operation is stalled and does not touch HI.
    issue(2'b11, 32'd50, 32'd8);
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h5555;
    bus.flush   = 1'b1;
    chk("mthi_busy_stall", 64'(bus.stall), 64'd1);
    step();
    bus.wr_hi = 1'b0;
    bus.flush = 1'b0;
    chk("flush_ignored_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("mthi_blocked_hi", 64'(bus.hi), 64'd2);
    chk("mthi_blocked_lo", 64'(bus.lo), 64'd6);
    step();

    // Reset in the middle of CALC.
    issue(2'b11, 32'd1000, 32'd3);
    repeat (10) step();
    chk("midreset_busy_before", 64'(bus.busy), 64'd1);
    reset       = 1'b1;
    bus.rd_hilo = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_busy",  64'(bus.busy),  64'd0);
    chk("midreset_hi",    64'(bus.hi),    64'd0);
    chk("midreset_lo",    64'(bus.lo),    64'd0);
    chk("midreset_stall", 64'(bus.stall), 64'd0);
    bus.rd_hilo = 1'b0;
    repeat (40) step();
    chk("midreset_no_done", 64'(bus.done), 64'd0);
    chk("midreset_hi_kept", 64'(bus.hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
